// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: datapath sizes,
// load funct3 encodings and the result-source selector.
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 16;
  localparam int ADDR_W = 5;
  localparam int IDX_W  = $clog2(NREG);

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic {
    SRC_EXU,
    SRC_LSU
  } wb_src_e;

  // x0 is hardwired and indices past NREG do not exist, so neither can be written or tracked
  function automatic logic reg_legal(input logic [ADDR_W-1:0] idx);
    return (idx != '0) && (int'(idx) < NREG);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter: picks the byte/half/word out of the aligned
// memory word, extends it to XLEN and flags misaligned or unknown load types.
module load_extend
  import wb_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ext_data,
  output logic            misalign,
  output logic            illegal
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (off)
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    ext_data = '0;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (funct3)
      LD_LB:  ext_data = {{(XLEN-8){byte_v[7]}}, byte_v};
      LD_LBU: ext_data = {{(XLEN-8){1'b0}}, byte_v};
      LD_LH: begin
        ext_data = {{(XLEN-16){half_v[15]}}, half_v};
        misalign = off[0];
      end
      LD_LHU: begin
        ext_data = {{(XLEN-16){1'b0}}, half_v};
        misalign = off[0];
      end
      LD_LW: begin
        ext_data = rdata;
        misalign = (off != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges LSU and EXU results onto the single register file
// write port and keeps the per-register busy scoreboard for issue stalls.
module wb_arbiter
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_valid,
  output logic              exu_ready,
  input  logic [ADDR_W-1:0] exu_rd,
  input  logic [XLEN-1:0]   exu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [2:0]        lsu_funct3,
  input  logic [1:0]        lsu_off,
  input  logic [XLEN-1:0]   lsu_rdata,
  output logic              lsu_err,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_busy,
  output logic              rd_wen,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]   rd_data
);

  logic              rd_wen_q,  rd_wen_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;
  logic              lsu_err_q, lsu_err_d;
  logic [NREG-1:0]   busy_q,    busy_d;

  wb_src_e         src;
  logic [XLEN-1:0] ld_data;
  logic            ld_misalign;
  logic            ld_illegal;

  load_extend u_load_extend (
    .funct3   (lsu_funct3),
    .off      (lsu_off),
    .rdata    (lsu_rdata),
    .ext_data (ld_data),
    .misalign (ld_misalign),
    .illegal  (ld_illegal)
  );

  // Loads are older than anything the EXU holds, so the LSU always wins
  assign lsu_ready = 1'b1;
  assign exu_ready = !lsu_valid;

  always_comb begin
    src       = lsu_valid ? SRC_LSU : SRC_EXU;
    rd_wen_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    lsu_err_d = 1'b0;
    if (src == SRC_LSU) begin
      if (ld_illegal || ld_misalign) begin
        lsu_err_d = 1'b1;
      end else if (reg_legal(lsu_rd)) begin
        rd_wen_d  = 1'b1;
        rd_addr_d = lsu_rd;
        rd_data_d = ld_data;
      end
    end else if (exu_valid && reg_legal(exu_rd)) begin
      rd_wen_d  = 1'b1;
      rd_addr_d = exu_rd;
      rd_data_d = exu_data;
    end
  end

  // Clear first so a fresh reservation on the write edge survives
  always_comb begin
    busy_d = busy_q;
    if (rd_wen_q) begin
      busy_d[rd_addr_q[IDX_W-1:0]] = 1'b0;
    end
    if (iss_valid && reg_legal(iss_rd)) begin
      busy_d[iss_rd[IDX_W-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_wen_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      lsu_err_q <= 1'b0;
      busy_q    <= '0;
    end else begin
      rd_wen_q  <= rd_wen_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      lsu_err_q <= lsu_err_d;
      busy_q    <= busy_d;
    end
  end

  assign rd_wen  = rd_wen_q;
  assign rd_addr = rd_addr_q;
  assign rd_data = rd_data_q;
  assign lsu_err = lsu_err_q;

  assign rs1_busy = reg_legal(rs1_addr) && busy_q[rs1_addr[IDX_W-1:0]];
  assign rs2_busy = reg_legal(rs2_addr) && busy_q[rs2_addr[IDX_W-1:0]];
  assign rd_busy  = reg_legal(iss_rd)   && busy_q[iss_rd[IDX_W-1:0]];

endmodule
